// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit line between NUM_REQ
// byte producers. Bit timing comes from a clk_in-domain counter, and each
// accepted byte is sent as an 8N1 frame: one start bit, eight data bits
// LSB first, one stop bit. The line idles high.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT),
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Last and second-to-last timer values of a bit period. frame_done is
    // registered, so it is set one cycle early so that it is high during the
    // final stop-bit cycle.
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [ID_W-1:0]  LAST_INIT  = ID_W'(NUM_REQ - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] timer_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             busy_r;
    logic             frame_done_r;
    logic [ID_W-1:0]  grant_id_r;
    logic [ID_W-1:0]  last_r;

    logic [ID_W:0]    pick_s;
    logic             found_s;
    logic [ID_W-1:0]  winner_s;
    logic [7:0]       win_byte_s;

    // Round-robin search: the first valid requester starting just after
    // 'last' and wrapping. The MSB of the result flags whether any
    // requester was found.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!res[ID_W] && valid[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection, its data byte, and the one-hot accept strobe.
    // req_ready is asserted only while idle.
    always_comb begin
        pick_s     = rr_pick(req_valid, last_r);
        found_s    = pick_s[ID_W];
        winner_s   = pick_s[ID_W-1:0];
        win_byte_s = 8'h00;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                win_byte_s   = req_data[8*i +: 8];
                req_ready[i] = found_s && (state_r == S_IDLE);
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // Frame sequencer: acceptance, bit timer, shift register and serial output.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            timer_r      <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            tx_r         <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            grant_id_r   <= '0;
            last_r       <= LAST_INIT;
        end else begin
            case (state_r)
                S_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (found_s) begin
                        shift_r    <= win_byte_s;
                        grant_id_r <= winner_s;
                        last_r     <= winner_s;
                        state_r    <= S_START;
                        busy_r     <= 1'b1;
                        tx_r       <= 1'b0;
                        timer_r    <= '0;
                        bit_idx_r  <= 3'd0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                S_START: begin
                    if (timer_r == BIT_LAST) begin
                        timer_r   <= '0;
                        state_r   <= S_DATA;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (timer_r == BIT_LAST) begin
                        timer_r <= '0;
                        shift_r <= {1'b0, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= S_STOP;
                            bit_idx_r <= 3'd0;
                            tx_r      <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        timer_r <= timer_r + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    tx_r <= 1'b1;
                    if (timer_r == BIT_LAST) begin
                        timer_r      <= '0;
                        state_r      <= S_IDLE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b0;
                    end else begin
                        timer_r      <= timer_r + CNT_W'(1);
                        frame_done_r <= (timer_r == BIT_PENULT);
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    timer_r      <= '0;
                    bit_idx_r    <= 3'd0;
                    tx_r         <= 1'b1;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter. A transaction-level model
// predicts grants and accepted bytes. A line monitor decodes every frame on
// tx and compares it against the predicted queue.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CPB     = 4;
    localparam int FRAME   = 10 * CPB;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } exp_t;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 frame_done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    int   seen_ids[$];

    // Model state: priority pointer, cycles until the line is free again, and
    // the number of accepts so far.
    int m_last;
    int m_wait;
    int m_accepts;

    // Monitor state.
    int         mon_pos;
    bit         mon_have;
    exp_t       mon_exp;
    int         shape_err;
    int         fd_err;
    logic [7:0] mon_byte;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of the reference model, evaluated after the inputs have settled.
    task automatic model_step();
        logic [NUM_REQ-1:0] exp_ready;
        int   w;
        bit   found;
        exp_t e;
        exp_ready = '0;
        w = 0;
        found = 1'b0;
        if (rst) begin
            m_wait = 0;
        end else if (m_wait == 0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int i;
                i = (m_last + k) % NUM_REQ;
                if (!found && req_valid[i]) begin
                    found = 1'b1;
                    w = i;
                end
            end
            chk("busy_idle", 32'(busy), 32'd0);
            chk("tx_idle", 32'(tx), 32'd1);
            if (found) exp_ready[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (found) begin
                e.id   = 8'(w);
                e.data = req_data[8*w +: 8];
                sb.push_back(e);
                m_last = w;
                m_wait = FRAME;
                m_accepts++;
            end
        end else begin
            chk("busy_frame", 32'(busy), 32'd1);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            m_wait--;
        end
    endtask

    task automatic step();
        #1;
        model_step();
        @(negedge clk_in);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int target, input int limit);
        int n;
        n = 0;
        while (m_accepts < target && n < limit) begin
            step();
            n++;
        end
        if (m_accepts < target) chk("accept_timeout", 32'(m_accepts), 32'(target));
    endtask

    task automatic model_reset();
        m_last = NUM_REQ - 1;
        m_wait = 0;
        sb.delete();
    endtask

    // Reset while idle. This is entered and left on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    function automatic logic exp_bit(input int pos, input logic [7:0] b);
        int k;
        k = (pos - 1) / CPB;
        if (k == 0) return 1'b0;
        else if (k == 9) return 1'b1;
        else return b[k-1];
    endfunction

    // Line monitor: decodes each frame on tx and checks it against the scoreboard.
    always @(negedge clk_in) begin
        if (rst) begin
            mon_pos = 0;
        end else if (mon_pos == 0) begin
            chk("frame_done_idle", 32'(frame_done), 32'd0);
            if (tx === 1'b0) begin
                mon_pos   = 1;
                shape_err = 0;
                fd_err    = 0;
                mon_byte  = 8'h00;
                if (sb.size() == 0) begin
                    mon_have = 1'b0;
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    mon_exp  = sb.pop_front();
                    mon_have = 1'b1;
                    chk("grant_id", 32'(grant_id), 32'(mon_exp.id));
                end
                seen_ids.push_back(int'(grant_id));
                if (busy !== 1'b1) shape_err++;
                if (frame_done !== 1'b0) fd_err++;
            end
        end else begin
            mon_pos++;
            if (mon_have && tx !== exp_bit(mon_pos, mon_exp.data)) shape_err++;
            if (busy !== 1'b1) shape_err++;
            if (frame_done !== (mon_pos == FRAME)) fd_err++;
            if ((mon_pos - 1) % CPB == CPB / 2 && (mon_pos - 1) / CPB >= 1 && (mon_pos - 1) / CPB <= 8)
                mon_byte[(mon_pos - 1) / CPB - 1] = tx;
            if (mon_pos == FRAME) begin
                if (mon_have) begin
                    chk("frame_tx", 32'(shape_err), 32'd0);
                    chk("frame_byte", 32'(mon_byte), 32'(mon_exp.data));
                    chk("frame_done", 32'(fd_err), 32'd0);
                end
                mon_pos = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        mon_pos   = 0;
        mon_have  = 1'b0;
        m_accepts = 0;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;

        // Single byte 0xA5 from requester 2.
        req_data[23:16] = 8'hA5;
        req_valid[2]    = 1'b1;
        run_until(m_accepts + 1, 20);
        req_valid = '0;
        run(FRAME + 5);
        chk("single_id", 32'(seen_ids[seen_ids.size()-1]), 32'd2);

        // Fairness with all four requesters valid.
        do_reset();
        seen_ids.delete();
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        run_until(m_accepts + 6, 6 * (FRAME + 2));
        req_valid = '0;
        run(FRAME + 5);
        chk("fair_count", 32'(seen_ids.size()), 32'd6);
        if (seen_ids.size() >= 6) begin
            chk("fair_0", 32'(seen_ids[0]), 32'd0);
            chk("fair_1", 32'(seen_ids[1]), 32'd1);
            chk("fair_2", 32'(seen_ids[2]), 32'd2);
            chk("fair_3", 32'(seen_ids[3]), 32'd3);
            chk("fair_4", 32'(seen_ids[4]), 32'd0);
            chk("fair_5", 32'(seen_ids[5]), 32'd1);
        end

        // Pointer skip: only requesters 1 and 3 valid after a grant to 1.
        base      = seen_ids.size();
        req_data  = $urandom;
        req_valid = 4'b1010;
        run_until(m_accepts + 2, 2 * (FRAME + 2));
        req_valid = '0;
        run(FRAME + 5);
        if (seen_ids.size() >= base + 2) begin
            chk("skip_first", 32'(seen_ids[base]), 32'd3);
            chk("skip_second", 32'(seen_ids[base+1]), 32'd1);
        end else begin
            chk("skip_count", 32'(seen_ids.size()), 32'(base + 2));
        end

        // Reset in the middle of data bit 4.
        req_data  = $urandom;
        req_valid = 4'b0001;
        run_until(m_accepts + 1, 10);
        req_valid = '0;
        run(21);
        @(posedge clk_in);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_fdone", 32'(frame_done), 32'd0);
        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rst       = 1'b0;
        req_data  = $urandom;
        req_valid = 4'b1001;
        run_until(m_accepts + 1, 10);
        req_valid = '0;
        run(FRAME + 5);
        chk("midrst_grant", 32'(seen_ids[seen_ids.size()-1]), 32'd0);

        // Changes to the granted requester's inputs during a frame are ignored.
        req_data  = 32'h00003C00;
        req_valid = 4'b0010;
        run_until(m_accepts + 1, 2 * (FRAME + 2));
        repeat (30) begin
            req_valid[1] = 1'($urandom);
            req_data     = $urandom;
            step();
        end
        req_valid = '0;
        run(FRAME);

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                req_valid = 4'($urandom);
                req_data  = $urandom;
            end
            step();
        end
        req_valid = '0;
        run(FRAME + 5);

        // Idle hold with no valid requesters.
        run(100);
        chk("idle_tx", 32'(tx), 32'd1);

        n = 0;
        while ((sb.size() != 0 || mon_pos != 0) && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit line between NUM_REQ byte producers (debug console, status reporter, etc.) using round-robin arbitration.
- Generates its own bit timing from clk_in with a CLKS_PER_BIT counter.
- Sequences each accepted byte as an 8N1 frame: start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the on-chip requesters and the TX pin. It replaces per-client toggled-clock baud generation with a single clk_in-domain bit timer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 10416, clk_in cycles per UART bit (100 MHz / 9600 baud). Minimum 2.
- CNT_W, $clog2(CLKS_PER_BIT), bit-timer width.
- ID_W, $clog2(NUM_REQ), grant id width.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte-valid.
- req_data  input  8*NUM_REQ  byte i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot accept strobe.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- grant_id  output  ID_W  index of the requester whose frame is in progress or was last sent.
- frame_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (async, rst high):
  - tx=1, busy=0, grant_id=0, req_ready=0, frame_done=0.
  - State IDLE; round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - Bit timer = 0, bit index = 0.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - Winner = first i with req_valid[i] high, searching from last+1 upward with wrap.
  - req_ready[winner] is combinationally high only in IDLE and only when req_valid[winner] is high. All other bits are 0, so at most one bit is ever high.
  - Accept edge = rising clk_in edge with req_valid[i] and req_ready[i] both high. On that edge:
    - latch req_data byte i into the shift register;
    - grant_id <= i and last <= i;
    - state <= START, tx <= 0, bit timer <= 0.
  - No valid input: remain in IDLE, tx=1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0 and tx <= shift[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - When the bit timer reaches CLKS_PER_BIT-1: timer <= 0 and shift right.
  - After bit index 7 completes: state <= STOP, tx <= 1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle, frame_done=1 (registered; it is high during that cycle only).
  - Then state <= IDLE.
- Timing:
  - tx falls in the first cycle after the accept edge.
  - A frame occupies exactly 10*CLKS_PER_BIT cycles.
  - The next accept can occur in the first IDLE cycle, so back-to-back frames have a 1-cycle minimum gap, with tx high.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps to 0. It never exceeds CLKS_PER_BIT-1.
- Inputs during a frame:
  - req_valid and req_data changes are ignored; only the latched byte is sent.
  - A requester may drop valid before acceptance with no effect.
- Reset mid-frame: tx returns to 1 immediately (async), the frame is abandoned, and the pointer is reset. No frame_done is emitted.
- busy = (state != IDLE), registered-equivalent and glitch-free.

Test Plan:
- Single byte, CLKS_PER_BIT=4: req_valid[2]=1, req_data byte2=0xA5.
  - req_ready[2] pulses one cycle; grant_id=2.
  - tx = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit (start, LSB-first 0xA5, stop).
  - frame_done high on cycle 40 after the accept edge; busy high for 40 cycles.
- Fairness: all four valid continuously with distinct bytes 0x10..0x13. Grant order is 0,1,2,3,0,1. Each frame is 40 cycles with a 1-cycle tx-high gap.
- Pointer skip: after grant to 1, only requesters 1 and 3 valid. The next grant is 3, then 1.
- Reset mid-frame: assert rst during DATA bit 4.
  - tx=1 and busy=0 asynchronously; no frame_done.
  - After release with req 0 and 3 valid, grant is 0.
- Ignored inputs: change req_data and toggle valid of the granted requester during DATA. The serial byte is unchanged and no req_ready is asserted until IDLE.
- Idle hold: no valid for 100 cycles. tx stays 1, busy=0, req_ready=0.
